// File: rtl/mg_output_packetizer_pkg.sv
// Shared definitions for the output packetizer: framing constants, FSM encodings
// and the captured response payload.
package mg_output_packetizer_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hCD;
  localparam int unsigned FRAME_BYTES       = 17;
  localparam int unsigned IDX_W             = 5;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(FRAME_BYTES - 1);

  localparam logic [0:0] PKT_IDLE = 1'b0;
  localparam logic [0:0] PKT_SEND = 1'b1;

  typedef struct packed {
    logic [31:0] status;
    logic [27:0] data_count;
    logic [31:0] address;
    logic [31:0] data;
  } frame_t;

endpackage

// File: rtl/mg_output_packetizer_frame_mux.sv
// Byte selector for one frame: index 0 is the sync byte, then status,
// padded data count, address and data, each MSB first.
module mg_frame_mux
  import mg_output_packetizer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic [IDX_W-1:0] idx,
  input  frame_t           frame,
  output logic [7:0]       tx_data
);

  logic [127:0] flat;

  assign flat = {frame.status, 4'h0, frame.data_count, frame.address, frame.data};

  // Indices beyond the last frame byte select zero.
  always_comb begin
    tx_data = 8'h00;
    if (idx == '0) begin
      tx_data = SYNC_BYTE;
    end
    for (int unsigned i = 1; i < FRAME_BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        tx_data = flat[128 - 8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mg_output_packetizer.sv
// Serialises wishbone-master responses into 17-byte framed valid/ready byte
// streams, with a one-frame holding buffer so the master never stalls.
module mg_output_packetizer
  import mg_output_packetizer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_en,
  input  logic [31:0] out_status,
  input  logic [31:0] out_address,
  input  logic [31:0] out_data,
  input  logic [27:0] out_data_count,
  output logic        out_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overflow
);

  logic [0:0]       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  frame_t           frame, frame_n;
  frame_t           hold, hold_n;
  logic             hold_v, hold_v_n;
  logic             overflow_n;
  frame_t           in_words;
  logic [7:0]       next_byte;

  assign in_words = {out_status, out_data_count, out_address, out_data};

  // The byte for the next cycle is selected from next-state index/frame so tx_data is registered.
  mg_frame_mux #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_frame_mux (
    .idx     (idx_n),
    .frame   (frame_n),
    .tx_data (next_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PKT_IDLE;
      idx       <= '0;
      frame     <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      overflow  <= 1'b0;
      out_ready <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      tx_data   <= 8'h00;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      frame     <= frame_n;
      hold      <= hold_n;
      hold_v    <= hold_v_n;
      overflow  <= overflow_n;
      out_ready <= ~hold_v_n;
      tx_valid  <= (state_n == PKT_SEND);
      busy      <= (state_n == PKT_SEND);
      tx_data   <= (state_n == PKT_SEND) ? next_byte : 8'h00;
    end
  end

  // A response arriving during the final-byte transfer goes through hold_n and is
  // pulled straight into the frame register, giving a back-to-back frame.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    frame_n    = frame;
    hold_n     = hold;
    hold_v_n   = hold_v;
    overflow_n = overflow;
    case (state)
      PKT_IDLE: begin
        if (out_en) begin
          frame_n = in_words;
          idx_n   = '0;
          state_n = PKT_SEND;
        end
      end
      PKT_SEND: begin
        if (out_en) begin
          if (hold_v) begin
            overflow_n = 1'b1;
          end else begin
            hold_n   = in_words;
            hold_v_n = 1'b1;
          end
        end
        if (tx_ready) begin
          if (idx == LAST_IDX) begin
            idx_n = '0;
            if (hold_v_n) begin
              frame_n  = hold_n;
              hold_v_n = 1'b0;
            end else begin
              state_n = PKT_IDLE;
            end
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_n = PKT_IDLE;
        idx_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mg_output_packetizer.sv
// Directed and randomized bench for mg_output_packetizer against a queue-level frame model.
module tb_mg_output_packetizer;

  logic        clk;
  logic        rst;
  logic        out_en;
  logic [31:0] out_status;
  logic [31:0] out_address;
  logic [31:0] out_data;
  logic [27:0] out_data_count;
  logic        out_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        busy;
  logic        overflow;

  mg_output_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .out_en         (out_en),
    .out_status     (out_status),
    .out_address    (out_address),
    .out_data       (out_data),
    .out_data_count (out_data_count),
    .out_ready      (out_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .busy           (busy),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [7:0] rx_q[$];

  // Model: the frame on the wire as a shifting byte image, plus one pending frame.
  logic [135:0] m_cur;
  logic [135:0] m_pend;
  int           m_len = 0;
  bit           m_pend_v = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_ordy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_len    = 0;
      m_pend_v = 1'b0;
      m_ovf    = 1'b0;
      m_ordy   = 1'b0;
    end else begin
      if (m_len > 0 && tx_ready) begin
        m_cur = m_cur << 8;
        m_len = m_len - 1;
      end
      if (out_en) begin
        if (m_pend_v) m_ovf = 1'b1;
        else begin
          m_pend   = {8'hCD, out_status, 4'h0, out_data_count, out_address, out_data};
          m_pend_v = 1'b1;
        end
      end
      if (m_len == 0 && m_pend_v) begin
        m_cur    = m_pend;
        m_len    = 17;
        m_pend_v = 1'b0;
      end
      m_ordy = !m_pend_v;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_valid", 32'(tx_valid), 32'(m_len > 0));
      chk("busy", 32'(busy), 32'(m_len > 0));
      chk("out_ready", 32'(out_ready), 32'(m_ordy));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_len > 0) chk("tx_data", 32'(tx_data), 32'(m_cur[135:128]));
      if (tx_valid && tx_ready && !rst) rx_q.push_back(tx_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input logic [27:0] c,
                      input logic [31:0] a, input logic [31:0] d);
    out_en = 1'b1; out_status = s; out_data_count = c; out_address = a; out_data = d;
    step();
    out_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_valid && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      n_err++;
      $display("FAIL wait_idle: tx_valid still high after %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic chk_frame1(input string tag);
    logic [7:0] exp1 [17] = '{8'hCD, 8'hFF, 8'hFF, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h01,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hAF};
    chk({tag, "_len"}, 32'(rx_q.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      if (i < rx_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp1[i]));
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; out_en = 1'b0; tx_ready = 1'b1;
    out_status = '0; out_address = '0; out_data = '0; out_data_count = '0;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_out_ready", 32'(out_ready), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_out_ready", 32'(out_ready), 32'd1);

    // Single frame at full rate.
    rx_q.delete();
    send(32'hFFFFFFFE, 28'h1, 32'h0, 32'h1EAF);
    cyc = 0;
    while (tx_valid && cyc < 100) begin
      cyc++;
      step();
    end
    chk("s1_cycles", 32'(cyc), 32'd17);
    chk_frame1("s1");
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_out_ready", 32'(out_ready), 32'd1);

    // Alternating backpressure.
    rx_q.delete();
    tx_ready = 1'b0;
    send(32'hFFFFFFFE, 28'h1, 32'h0, 32'h1EAF);
    tx_ready = 1'b1;
    cyc = 0;
    while (tx_valid && cyc < 100) begin
      cyc++;
      step();
      tx_ready = !tx_ready;
    end
    chk("s2_cycles", 32'(cyc), 32'd33);
    chk_frame1("s2");
    tx_ready = 1'b1;
    step();

    // Back-to-back via the holding buffer.
    rx_q.delete();
    send(32'h1, 28'h2, 32'h3, 32'h4);
    repeat (4) step();
    send(32'h5, 28'h6, 32'h7, 32'h12345678);
    chk("s3_out_ready_low", 32'(out_ready), 32'd0);
    wait_idle();
    chk("s3_len", 32'(rx_q.size()), 32'd34);
    if (rx_q.size() == 34) begin
      chk("s3_sync2", 32'(rx_q[17]), 32'hCD);
      chk("s3_last", 32'(rx_q[33]), 32'h78);
    end

    // Overflow: #2 held, #3 and #4 dropped.
    rx_q.delete();
    send(32'hA, 28'hB, 32'hC, 32'hD1);
    step();
    send(32'hA, 28'hB, 32'hC, 32'hD2);
    step();
    send(32'hA, 28'hB, 32'hC, 32'hD3);
    send(32'hA, 28'hB, 32'hC, 32'hD4);
    chk("s4_overflow", 32'(overflow), 32'd1);
    wait_idle();
    repeat (10) step();
    chk("s4_sticky", 32'(overflow), 32'd1);
    chk("s4_len", 32'(rx_q.size()), 32'd34);
    if (rx_q.size() == 34) chk("s4_last", 32'(rx_q[33]), 32'hD2);

    // out_en coinciding with the final-byte transfer.
    do_reset();
    rx_q.delete();
    send(32'h11, 28'h22, 32'h33, 32'h44);
    repeat (16) step();
    send(32'h55, 28'h66, 32'h77, 32'h88);
    wait_idle();
    chk("s5_len", 32'(rx_q.size()), 32'd34);
    if (rx_q.size() == 34) begin
      chk("s5_sync2", 32'(rx_q[17]), 32'hCD);
      chk("s5_last", 32'(rx_q[33]), 32'h88);
    end
    chk("s5_overflow", 32'(overflow), 32'd0);

    // Reset mid-frame with the buffer full.
    send(32'h1, 28'h1, 32'h1, 32'h1);
    step();
    send(32'h2, 28'h2, 32'h2, 32'h2);
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("s6_tx_valid", 32'(tx_valid), 32'd0);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();
    chk("s6_out_ready", 32'(out_ready), 32'd1);
    rx_q.delete();
    send(32'hDEADBEEF, 28'hABCDEF0, 32'hCAFEF00D, 32'h0BADC0DE);
    wait_idle();
    chk("s6_len", 32'(rx_q.size()), 32'd17);
    if (rx_q.size() == 17) begin
      chk("s6_sync", 32'(rx_q[0]), 32'hCD);
      chk("s6_cnt_hi", 32'(rx_q[5]), 32'h0A);
    end

    // Randomized traffic, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      out_en         = ($urandom_range(0, 9) == 0);
      out_status     = $urandom;
      out_address    = $urandom;
      out_data       = $urandom;
      out_data_count = 28'($urandom);
      tx_ready       = ($urandom_range(0, 3) != 0);
      rst            = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; out_en = 1'b0; tx_ready = 1'b1;
    step();
    wait_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
